elevator_scheduler: RTL

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 42 ++++
 rtl/elevator_door_timer.sv | 31 +++
 rtl/elevator_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-floor elevator scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        MOVE_UP = 2'd2,
        MOVE_DN = 2'd3
    } state_t;

    localparam logic [1:0] FLOOR_1    = 2'd1;
    localparam logic [1:0] FLOOR_2    = 2'd2;
    localparam logic [1:0] FLOOR_3    = 2'd3;
    localparam int         NUM_FLOORS = 3;

    // One-hot floor select; bit0 = floor 1. Unknown floor selects nothing.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] floor);
        case (floor)
            FLOOR_1: floor_onehot = 3'b001;
            FLOOR_2: floor_onehot = 3'b010;
            FLOOR_3: floor_onehot = 3'b100;
            default: floor_onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [1:0] floor);
        case (floor)
            FLOOR_1: above_mask = 3'b110;
            FLOOR_2: above_mask = 3'b100;
            default: above_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [1:0] floor);
        case (floor)
            FLOOR_2: below_mask = 3'b001;
            FLOOR_3: below_mask = 3'b011;
            default: below_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Door dwell counter: loads DOOR_CYCLES-1, counts down while running, flags zero.
module elevator_door_timer #(
    parameter int DOOR_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic hold,
    input  logic run,
    output logic expired
);
    localparam logic [7:0] RELOAD = 8'(DOOR_CYCLES - 1);

    logic [7:0] count_r;

    // Down-counter with load/hold taking priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (load || hold) begin
            count_r <= RELOAD;
        end else if (run && (count_r != 8'd0)) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == 8'd0);

endmodule

// File: rtl/elevator_scheduler.sv
// Three-floor collective elevator scheduler with latched hall/car lamps.
// Optional DOOR_HOLD_EN adds a door_hold input that keeps the doors open.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] hall_up_req,
    input  logic [1:0] hall_dn_req,
    input  logic [2:0] car_req,
    input  logic [1:0] car_floor,
    input  logic       car_at_floor,
`ifdef DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic       move_up,
    output logic       move_dn,
    output logic       door_open,
    output logic       dir_up,
    output logic [1:0] hall_up_lamp,
    output logic [1:0] hall_dn_lamp,
    output logic [2:0] car_lamp
);
    state_t state_r, next_state_s;

    logic [NUM_FLOORS-1:0] fsel_s, up_f_s, dn_f_s, any_f_s, req_up_f_s, req_dn_f_s;
    logic [NUM_FLOORS-1:0] clr_car_s, clr_up_f_s, clr_dn_f_s, sup_car_s, sup_up_f_s, sup_dn_f_s;
    logic above_s, below_s, beyond_s, here_car_s, here_up_s, here_dn_s, here_s;
    logic enter_open_s, in_open_s, reload_s, hold_s, door_expired_s;
    logic move_up_s, move_dn_s, door_open_s, dir_up_s;
    logic [1:0] hall_up_lamp_s, hall_dn_lamp_s;
    logic [2:0] car_lamp_s;

    // Lamps and pulses re-expressed per floor (bit0 = floor 1).
    assign fsel_s     = floor_onehot(car_floor);
    assign up_f_s     = {1'b0, hall_up_lamp};
    assign dn_f_s     = {hall_dn_lamp, 1'b0};
    assign any_f_s    = car_lamp | up_f_s | dn_f_s;
    assign req_up_f_s = {1'b0, hall_up_req};
    assign req_dn_f_s = {hall_dn_req, 1'b0};

    assign above_s    = |(any_f_s & above_mask(car_floor));
    assign below_s    = |(any_f_s & below_mask(car_floor));
    assign beyond_s   = dir_up ? above_s : below_s;
    assign here_car_s = |(car_lamp & fsel_s);
    assign here_up_s  = |(up_f_s & fsel_s);
    assign here_dn_s  = |(dn_f_s & fsel_s);
    // Only count a floor call that opening here would actually clear, so an
    // opposite-direction hall call cannot pin the car at this floor.
    assign here_s     = here_car_s | (dir_up ? here_up_s : here_dn_s)
                      | ((dir_up ? here_dn_s : here_up_s) & ~beyond_s);

    assign in_open_s    = (state_r == OPEN);
    assign enter_open_s = (next_state_s == OPEN) && !in_open_s;
    assign sup_car_s    = fsel_s & {NUM_FLOORS{in_open_s}};
    assign sup_up_f_s   = fsel_s & {NUM_FLOORS{in_open_s && dir_up}};
    assign sup_dn_f_s   = fsel_s & {NUM_FLOORS{in_open_s && !dir_up}};
    assign reload_s     = (|(car_req & sup_car_s)) | (|(req_up_f_s & sup_up_f_s))
                        | (|(req_dn_f_s & sup_dn_f_s));
    assign clr_car_s    = fsel_s & {NUM_FLOORS{enter_open_s}};
    assign clr_up_f_s   = fsel_s & {NUM_FLOORS{enter_open_s && (dir_up || !beyond_s)}};
    assign clr_dn_f_s   = fsel_s & {NUM_FLOORS{enter_open_s && (!dir_up || !beyond_s)}};

`ifdef DOOR_HOLD_EN
    assign hold_s = door_hold && in_open_s;
`else
    assign hold_s = 1'b0;
`endif

    elevator_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (enter_open_s || reload_s),
        .hold    (hold_s),
        .run     (in_open_s),
        .expired (door_expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Dispatch, stop and door-close decisions.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (car_floor == 2'd0)       next_state_s = IDLE;
                else if (here_s)             next_state_s = OPEN;
                else if (above_s && below_s) next_state_s = dir_up ? MOVE_UP : MOVE_DN;
                else if (above_s)            next_state_s = MOVE_UP;
                else if (below_s)            next_state_s = MOVE_DN;
                else                         next_state_s = IDLE;
            end
            MOVE_UP: begin
                if (car_at_floor && (car_floor != 2'd0) && ((car_floor == FLOOR_3)
                        || here_car_s || here_up_s || !above_s)) next_state_s = OPEN;
                else                                             next_state_s = MOVE_UP;
            end
            MOVE_DN: begin
                if (car_at_floor && (car_floor != 2'd0) && ((car_floor == FLOOR_1)
                        || here_car_s || here_dn_s || !below_s)) next_state_s = OPEN;
                else                                             next_state_s = MOVE_DN;
            end
            OPEN: begin
                if (reload_s)            next_state_s = OPEN;
                else if (door_expired_s) next_state_s = IDLE;
                else                     next_state_s = OPEN;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Moore output decode of the upcoming state, plus lamp and direction updates.
    always_comb begin
        move_up_s   = 1'b0;
        move_dn_s   = 1'b0;
        door_open_s = 1'b0;
        case (next_state_s)
            MOVE_UP: move_up_s   = 1'b1;
            MOVE_DN: move_dn_s   = 1'b1;
            OPEN:    door_open_s = 1'b1;
            default: door_open_s = 1'b0;
        endcase
        dir_up_s = dir_up;
        if ((next_state_s == MOVE_UP) && (state_r != MOVE_UP))      dir_up_s = 1'b1;
        else if ((next_state_s == MOVE_DN) && (state_r != MOVE_DN)) dir_up_s = 1'b0;
        else if (enter_open_s && !beyond_s)                         dir_up_s = ~dir_up;
        else                                                        dir_up_s = dir_up;
        car_lamp_s     = (car_lamp & ~clr_car_s) | (car_req & ~sup_car_s);
        hall_up_lamp_s = (hall_up_lamp & ~clr_up_f_s[1:0]) | (hall_up_req & ~sup_up_f_s[1:0]);
        hall_dn_lamp_s = (hall_dn_lamp & ~clr_dn_f_s[2:1]) | (hall_dn_req & ~sup_dn_f_s[2:1]);
    end

    // Output, direction and lamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_up      <= 1'b0;
            move_dn      <= 1'b0;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
            car_lamp     <= 3'b000;
            hall_up_lamp <= 2'b00;
            hall_dn_lamp <= 2'b00;
        end else begin
            move_up      <= move_up_s;
            move_dn      <= move_dn_s;
            door_open    <= door_open_s;
            dir_up       <= dir_up_s;
            car_lamp     <= car_lamp_s;
            hall_up_lamp <= hall_up_lamp_s;
            hall_dn_lamp <= hall_dn_lamp_s;
        end
    end

endmodule
